t_ff: RTL and testbench

Synchronous toggle flip-flop bank built on an internal D-register: each bit of `Q` inverts on a rising clock edge when its `T` bit is 1 and holds when it is 0. It is a leaf storage primitive in the flip-flop library, used wherever per-bit toggle state is needed (divide-by-2 stages, ripple/sync counter cells, parity trackers). The default configuration is a single-bit T flip-flop.

---
 rtl/t_ff_pkg.sv | 16 +
 rtl/d_ff.sv | 22 ++
 rtl/t_ff.sv | 55 +++++
 tb/tb_t_ff.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// Shared constants and types for the toggle flip-flop bank.
// The next-state select enumerates the per-edge priority: reset, then load, then toggle.
package t_ff_pkg;

    localparam int T_FF_DEFAULT_WIDTH = 1;

    // Replicated across WIDTH bits by the user of this constant.
    localparam logic T_FF_DEFAULT_RESET_BIT = 1'b0;

    typedef enum logic [1:0] {
        SEL_RESET  = 2'd0,
        SEL_LOAD   = 2'd1,
        SEL_TOGGLE = 2'd2
    } next_sel_t;

endpackage

// File: rtl/d_ff.sv
// WIDTH-bit rising-edge D-register with synchronous active-high reset to a parameterised value.
module d_ff
    import t_ff_pkg::*;
#(
    parameter int                 WIDTH       = T_FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{T_FF_DEFAULT_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/t_ff.sv
// Bank of independent T flip-flops: next-state logic around a single d_ff register.
// Define T_FF_LOAD_EN to add a synchronous parallel load ranked between reset and toggle.
module t_ff
    import t_ff_pkg::*;
#(
    parameter int                 WIDTH       = T_FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{T_FF_DEFAULT_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
`ifdef T_FF_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`endif
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    next_sel_t        sel;
    logic [WIDTH-1:0] d;

    // The register also resets itself; driving RESET_VALUE keeps D meaningful in that case too.
    always_comb begin
        sel = SEL_TOGGLE;
        d   = Q ^ T;
        if (rst) begin
            sel = SEL_RESET;
`ifdef T_FF_LOAD_EN
        end else if (load) begin
            sel = SEL_LOAD;
`endif
        end
        case (sel)
            SEL_RESET:  d = RESET_VALUE;
`ifdef T_FF_LOAD_EN
            SEL_LOAD:   d = load_data;
`endif
            default:    d = Q ^ T;
        endcase
    end

    d_ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (Q)
    );

    assign Qn = ~Q;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff: a single-bit instance and a 4-bit instance with RESET_VALUE 4'b1010.
// Load checks are compiled only when T_FF_LOAD_EN is defined.
module tb_t_ff;

    logic       clk;
    logic       rst;
    logic       t1;
    logic [0:0] q1;
    logic [0:0] qn1;
    logic [3:0] t4;
    logic [3:0] q4;
    logic [3:0] qn4;
`ifdef T_FF_LOAD_EN
    logic       load1;
    logic [0:0] loadData1;
    logic       load4;
    logic [3:0] loadData4;
`endif

    int checkCount;
    int errorCount;

    t_ff dutNarrow (
        .clk       (clk),
        .rst       (rst),
`ifdef T_FF_LOAD_EN
        .load      (load1),
        .load_data (loadData1),
`endif
        .T         (t1),
        .Q         (q1),
        .Qn        (qn1)
    );

    t_ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1010)
    ) dutWide (
        .clk       (clk),
        .rst       (rst),
`ifdef T_FF_LOAD_EN
        .load      (load4),
        .load_data (loadData4),
`endif
        .T         (t4),
        .Q         (q4),
        .Qn        (qn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] togglePattern [4];
    logic [0:0] holdToggleExp [4];

    initial begin
        checkCount = 0;
        errorCount = 0;
        togglePattern[0] = 4'd0;
        togglePattern[1] = 4'd1;
        togglePattern[2] = 4'd0;
        togglePattern[3] = 4'd1;
        holdToggleExp[0] = 1'b0;
        holdToggleExp[1] = 1'b1;
        holdToggleExp[2] = 1'b1;
        holdToggleExp[3] = 1'b0;
`ifdef T_FF_LOAD_EN
        load1     = 1'b0;
        loadData1 = 1'b0;
        load4     = 1'b0;
        loadData4 = 4'b0000;
`endif

        // Reset with toggle requested: reset must win on both instances.
        rst = 1'b1;
        t1  = 1'b1;
        t4  = 4'b1111;
        applyStimulus();
        checkOutput("reset_q1", 32'(q1), 32'd0);
        checkOutput("reset_qn1", 32'(qn1), 32'd1);
        checkOutput("reset_q4", 32'(q4), 32'hA);
        checkOutput("reset_qn4", 32'(qn4), 32'h5);

        rst = 1'b0;
        t4  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            t1 = togglePattern[i][0];
            applyStimulus();
            checkOutput($sformatf("holdtoggle_%0d", i), 32'(q1), 32'(holdToggleExp[i]));
        end
        checkOutput("wide_hold", 32'(q4), 32'hA);

        t4 = 4'b0110;
        t1 = 1'b0;
        applyStimulus();
        checkOutput("wide_indep_q", 32'(q4), 32'hC);
        checkOutput("wide_indep_qn", 32'(qn4), 32'h3);

        // Sustained toggle from Q=0 gives 1,0,1,0,...
        t4 = 4'b0000;
        t1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            checkOutput($sformatf("cont_q_%0d", i), 32'(q1), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cont_qn_%0d", i), 32'(qn1), (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // A pulse on T while the clock is low must not be captured.
        t1 = 1'b0;
        @(negedge clk);
        #1 t1 = 1'b1;
        #1 t1 = 1'b0;
        applyStimulus();
        checkOutput("glitch_ignored", 32'(q1), 32'd0);

        t1 = 1'b1;
        applyStimulus();
        checkOutput("pre_rst_q1", 32'(q1), 32'd1);

        rst = 1'b1;
        t1  = 1'b1;
        t4  = 4'b1111;
        applyStimulus();
        checkOutput("rst_prio_q1", 32'(q1), 32'd0);
        checkOutput("rst_prio_q4", 32'(q4), 32'hA);

        rst = 1'b0;
        t1  = 1'b0;
        t4  = 4'b1010;
        applyStimulus();
        checkOutput("wide_clear", 32'(q4), 32'h0);

`ifdef T_FF_LOAD_EN
        load4     = 1'b1;
        loadData4 = 4'b1001;
        t4        = 4'b1111;
        applyStimulus();
        checkOutput("load_wins", 32'(q4), 32'h9);

        load4 = 1'b0;
        t4    = 4'b0001;
        applyStimulus();
        checkOutput("after_load", 32'(q4), 32'h8);

        rst   = 1'b1;
        load4 = 1'b1;
        t4    = 4'b0000;
        applyStimulus();
        checkOutput("rst_over_load", 32'(q4), 32'hA);
        rst   = 1'b0;
        load4 = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
